line_avg_filter: RTL



---
 rtl/line_avg_filter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/line_avg_filter.sv
`default_nettype none
// ============================================================================
//  Module   : line_avg_filter
//  Purpose  : Vertical 3-tap line filter for packed multi-channel video
//             pixels. Two line buffers hold the two previous lines; each
//             output pixel is bypass, a two-line average, a [1 2 1]/4
//             average or a one-line delay of the input column. Rounding is
//             applied. Edge lines at the top of a frame are replicated.
//             The filter mode is latched only at a line boundary.
//  Ports    : iCLK   - pixel clock
//             iRST_N - asynchronous active-low reset
//             iSOF   - start-of-frame pulse (restarts column and line count)
//             iMODE  - requested mode (0 bypass, 1 avg2, 2 [1 2 1]/4, 3 delay)
//             iDVAL  - input pixel valid
//             iDATA  - input pixel, channel k at [k*DW +: DW]
//             oDATA  - filtered pixel, registered
//             oDVAL  - output valid (iDVAL delayed by one cycle)
//             oMODE  - mode currently applied
//  Revision : 1.0 - initial release
// ============================================================================
module line_avg_filter #(
    parameter int DW       = 8,
    parameter int CH       = 2,
    parameter int LINE_LEN = 640,
    parameter int AW       = 10
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iSOF,
    input  logic [1:0]       iMODE,
    input  logic             iDVAL,
    input  logic [CH*DW-1:0] iDATA,
    output logic [CH*DW-1:0] oDATA,
    output logic             oDVAL,
    output logic [1:0]       oMODE
);

    localparam int            c_W    = CH * DW;
    localparam logic [AW-1:0] c_LAST = AW'(LINE_LEN - 1);

    localparam logic [1:0] c_MODE_BYPASS = 2'd0;
    localparam logic [1:0] c_MODE_AVG2   = 2'd1;
    localparam logic [1:0] c_MODE_121    = 2'd2;

    // Line buffers: LB1 holds the previous line, LB2 the one before.
    logic [c_W-1:0] r_lb1 [0:LINE_LEN-1];
    logic [c_W-1:0] r_lb2 [0:LINE_LEN-1];

    logic [AW-1:0]  r_col;
    logic [1:0]     r_lc;
    logic [1:0]     r_mode;
    logic [c_W-1:0] r_data;
    logic           r_dval;

    // Start-of-frame overrides the stored position in the same cycle, so a
    // pixel arriving with iSOF is column 0 of line 0.
    logic [AW-1:0]  w_col;
    logic [1:0]     w_lc;
    logic           w_line_start;
    logic [1:0]     w_mode;
    logic [c_W-1:0] w_t0, w_rd1, w_rd2, w_t1, w_t2, w_res;
    logic           w_wrap;

    assign w_col        = iSOF ? '0 : r_col;
    assign w_lc         = iSOF ? 2'd0 : r_lc;
    assign w_line_start = (w_col == '0);
    // The column-0 pixel already uses the mode being latched this cycle.
    assign w_mode       = w_line_start ? iMODE : r_mode;
    assign w_wrap       = (w_col == c_LAST);

    // Asynchronous read gives read-before-write within the pixel cycle.
    assign w_t0  = iDATA;
    assign w_rd1 = r_lb1[w_col];
    assign w_rd2 = r_lb2[w_col];

    // Edge replication at frame top: missing lines are copied from the
    // nearest valid one.
    assign w_t1 = (w_lc == 2'd0) ? w_t0 : w_rd1;
    assign w_t2 = (w_lc == 2'd0) ? w_t0 :
                  (w_lc == 2'd1) ? w_rd1 : w_rd2;

    // Per-channel arithmetic; DW+2 bit sums keep rounding from overflowing.
    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [DW-1:0] w_a, w_b, w_c;
        logic [DW+1:0] w_s1, w_s2;

        assign w_a  = w_t0[k*DW +: DW];
        assign w_b  = w_t1[k*DW +: DW];
        assign w_c  = w_t2[k*DW +: DW];
        assign w_s1 = {2'b00, w_a} + {2'b00, w_b} + (DW+2)'(1);
        assign w_s2 = {2'b00, w_a} + {1'b0, w_b, 1'b0} + {2'b00, w_c}
                    + (DW+2)'(2);

        assign w_res[k*DW +: DW] =
            (w_mode == c_MODE_BYPASS) ? w_a         :
            (w_mode == c_MODE_AVG2)   ? w_s1[DW:1]  :
            (w_mode == c_MODE_121)    ? w_s2[DW+1:2] :
                                        w_b;
    end

    // Line buffer storage; contents are deliberately not reset.
    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            r_lb1[w_col] <= w_t0;
            r_lb2[w_col] <= w_rd1;
        end
    end

    // Position, mode and output registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_col  <= '0;
            r_lc   <= 2'd0;
            r_mode <= 2'd0;
            r_data <= '0;
            r_dval <= 1'b0;
        end else begin
            r_dval <= iDVAL;
            if (iDVAL) begin
                r_data <= w_res;
                if (w_line_start) begin
                    r_mode <= iMODE;
                end
                if (w_wrap) begin
                    r_col <= '0;
                    r_lc  <= (w_lc == 2'd2) ? 2'd2 : w_lc + 2'd1;
                end else begin
                    r_col <= w_col + AW'(1);
                    r_lc  <= w_lc;
                end
            end else begin
                r_col <= w_col;
                r_lc  <= w_lc;
            end
        end
    end

    assign oDATA = r_data;
    assign oDVAL = r_dval;
    assign oMODE = r_mode;

endmodule
`default_nettype wire
